logic_analyzer_capture: RTL and testbench



---
 rtl/logic_analyzer_capture.sv | 178 +++++++++++++++++
 tb/tb_logic_analyzer_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_analyzer_capture.sv
// Sampled-probe capture engine: waits for a masked trigger, stores a fixed number of samples
// in a FIFO and hands them to the DMA read channel as length-announced bursts.
module logic_analyzer_capture #(
   parameter int FIFO_DEPTH = 512,
   parameter int BURST_LEN  = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        capture_rstn,
   input  logic        cfg_start,
   input  logic [15:0] cfg_sample_div,
   input  logic [31:0] cfg_trig_mask,
   input  logic [31:0] cfg_trig_value,
   input  logic [31:0] cfg_sample_count,
   input  logic [31:0] probe_in,
   output logic        busy,
   output logic        triggered,
   output logic        overflow,
   output logic        done,
   output logic        rd_data_burst_valid,
   input  logic        rd_data_burst_ready,
   output logic [7:0]  rd_data_burst,
   output logic        rd_data_valid,
   input  logic        rd_data_ready,
   output logic [31:0] rd_data,
   output logic        rd_data_last
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [LW-1:0] LVL_BURST = LW'(BURST_LEN);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
   localparam logic [7:0]    FULL_BURST_M1 = 8'(BURST_LEN - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_FLUSH   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   logic [2:0]    state_r, state_next_s;
   logic [15:0]   div_cnt_r;
   logic [31:0]   sample_cnt_r;
   logic [31:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [LW-1:0] level_r;
   logic          burst_open_r;
   logic [8:0]    fetch_cnt_r;

   logic          sampling_s, tick_s, trig_hit_s, arm_s, full_s, take_s, wr_en_s, drop_s;
   logic          burst_hs_s, word_hs_s, close_s, bus_idle_s, offer_full_s, offer_part_s, load_s;
   logic [8:0]    fetch_cnt_s;

   assign sampling_s   = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
   assign tick_s       = sampling_s && (div_cnt_r == cfg_sample_div);
   assign trig_hit_s   = ((probe_in ^ cfg_trig_value) & cfg_trig_mask) == 32'd0;
   assign arm_s        = cfg_start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign full_s       = (level_r == LVL_FULL);
   assign take_s       = tick_s && (((state_r == ST_ARMED) && trig_hit_s) || (state_r == ST_CAPTURE));
   assign wr_en_s      = take_s && !full_s;
   assign drop_s       = take_s && full_s;
   assign burst_hs_s   = rd_data_burst_valid && rd_data_burst_ready;
   assign word_hs_s    = rd_data_valid && rd_data_ready;
   assign close_s      = word_hs_s && rd_data_last;
   // A closing burst has already popped all its words, so the level is current for a new offer.
   assign bus_idle_s   = (!burst_open_r || close_s) && !rd_data_burst_valid;
   assign offer_full_s = bus_idle_s && (level_r >= LVL_BURST);
   assign offer_part_s = bus_idle_s && (state_r == ST_FLUSH) && (level_r != {LW{1'b0}})
                         && (level_r < LVL_BURST);
   // The first word is fetched in the burst handshake cycle itself.
   assign fetch_cnt_s  = burst_hs_s ? ({1'b0, rd_data_burst} + 9'd1) : fetch_cnt_r;
   assign load_s       = (fetch_cnt_s != 9'd0) && (!rd_data_valid || rd_data_ready);

   // Next-state decode of the capture sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (arm_s) begin
               if (cfg_sample_count == 32'd0) state_next_s = ST_DONE;
               else                           state_next_s = ST_ARMED;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_ARMED: begin
            if (tick_s && trig_hit_s) begin
               if (cfg_sample_count == 32'd1) state_next_s = ST_FLUSH;
               else                           state_next_s = ST_CAPTURE;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_CAPTURE: begin
            if (tick_s && ((sample_cnt_r + 32'd1) == cfg_sample_count)) state_next_s = ST_FLUSH;
            else                                                         state_next_s = state_r;
         end
         ST_FLUSH: begin
            if ((level_r == {LW{1'b0}}) && bus_idle_s) state_next_s = ST_DONE;
            else                                        state_next_s = state_r;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Sample storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en_s) mem_r[wr_ptr_r] <= probe_in;
   end

   // Sequencer, divider, FIFO bookkeeping and the DMA burst/data channel.
   always_ff @(posedge clk) begin
      if (!rstn || !capture_rstn) begin
         state_r             <= ST_IDLE;
         busy                <= 1'b0;
         done                <= 1'b0;
         triggered           <= 1'b0;
         overflow            <= 1'b0;
         div_cnt_r           <= 16'd0;
         sample_cnt_r        <= 32'd0;
         wr_ptr_r            <= {AW{1'b0}};
         rd_ptr_r            <= {AW{1'b0}};
         level_r             <= {LW{1'b0}};
         burst_open_r        <= 1'b0;
         fetch_cnt_r         <= 9'd0;
         rd_data_burst_valid <= 1'b0;
         rd_data_burst       <= 8'd0;
         rd_data_valid       <= 1'b0;
         rd_data             <= 32'd0;
         rd_data_last        <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy    <= (state_next_s == ST_ARMED) || (state_next_s == ST_CAPTURE) || (state_next_s == ST_FLUSH);
         done    <= (state_next_s == ST_DONE);
         div_cnt_r <= (sampling_s && !tick_s) ? (div_cnt_r + 16'd1) : 16'd0;

         if (arm_s)       sample_cnt_r <= 32'd0;
         else if (take_s) sample_cnt_r <= sample_cnt_r + 32'd1;

         if (arm_s)                                      triggered <= 1'b0;
         else if (tick_s && (state_r == ST_ARMED) && trig_hit_s) triggered <= 1'b1;

         if (arm_s)       overflow <= 1'b0;
         else if (drop_s) overflow <= 1'b1;

         if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         if (load_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         case ({wr_en_s, load_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase

         if (burst_hs_s) begin
            rd_data_burst_valid <= 1'b0;
         end else if (offer_full_s) begin
            rd_data_burst_valid <= 1'b1;
            rd_data_burst       <= FULL_BURST_M1;
         end else if (offer_part_s) begin
            rd_data_burst_valid <= 1'b1;
            rd_data_burst       <= 8'(level_r - LVL_ONE);
         end

         if (burst_hs_s)   burst_open_r <= 1'b1;
         else if (close_s) burst_open_r <= 1'b0;

         fetch_cnt_r <= load_s ? (fetch_cnt_s - 9'd1) : fetch_cnt_s;
         if (load_s) begin
            rd_data       <= mem_r[rd_ptr_r];
            rd_data_last  <= (fetch_cnt_s == 9'd1);
            rd_data_valid <= 1'b1;
         end else if (word_hs_s) begin
            rd_data_valid <= 1'b0;
            rd_data_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_logic_analyzer_capture.sv
// Bench for logic_analyzer_capture: probe history is recorded per clock and the expected
// sample stream and burst split are derived from the arm edge, divider and trigger rules.
module tb_logic_analyzer_capture;
   localparam int DEPTH = 512;
   localparam int BL    = 64;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        capture_rstn = 1'b1;
   logic        cfg_start = 1'b0;
   logic [15:0] cfg_sample_div = 16'd0;
   logic [31:0] cfg_trig_mask = 32'd0;
   logic [31:0] cfg_trig_value = 32'd0;
   logic [31:0] cfg_sample_count = 32'd0;
   logic [31:0] probe_in = 32'd0;
   logic        busy, triggered, overflow, done;
   logic        rd_data_burst_valid;
   logic        rd_data_burst_ready = 1'b0;
   logic [7:0]  rd_data_burst;
   logic        rd_data_valid;
   logic        rd_data_ready = 1'b0;
   logic [31:0] rd_data;
   logic        rd_data_last;

   int checks = 0;
   int errors = 0;
   logic [31:0] hist [65536];
   int k = 0;
   int k0 = 0;
   int arm_edge = 0;
   int pmode = 0;
   int rmode = 0;
   int bmode = 0;
   logic [31:0] got_q [$];
   logic        got_last_q [$];
   int          blen_q [$];
   logic [31:0] exp_q [$];

   logic_analyzer_capture #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
      .clk(clk), .rstn(rstn), .capture_rstn(capture_rstn), .cfg_start(cfg_start),
      .cfg_sample_div(cfg_sample_div), .cfg_trig_mask(cfg_trig_mask),
      .cfg_trig_value(cfg_trig_value), .cfg_sample_count(cfg_sample_count),
      .probe_in(probe_in), .busy(busy), .triggered(triggered), .overflow(overflow),
      .done(done), .rd_data_burst_valid(rd_data_burst_valid),
      .rd_data_burst_ready(rd_data_burst_ready), .rd_data_burst(rd_data_burst),
      .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
      .rd_data_last(rd_data_last)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Input driver: k is the index of the rising edge that samples the values set here.
   initial begin
      forever begin
         @(negedge clk);
         k = k + 1;
         if (pmode == 0) probe_in = 32'(k - k0);
         else            probe_in = $urandom;
         hist[k % 65536] = probe_in;
         rd_data_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         rd_data_burst_ready = (bmode == 0) ? 1'b0 : (bmode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: records handshakes seen by the next edge and checks stability under stall.
   initial begin
      logic        stall_w, stall_b, prev_l;
      logic [31:0] prev_d;
      logic [7:0]  prev_b;
      stall_w = 1'b0; stall_b = 1'b0; prev_l = 1'b0; prev_d = 32'd0; prev_b = 8'd0;
      forever begin
         @(negedge clk); #2;
         if (!rstn || !capture_rstn) begin
            stall_w = 1'b0;
            stall_b = 1'b0;
         end else begin
            if (stall_w) check("data_hold", {rd_data_valid, rd_data_last, rd_data}, {1'b1, prev_l, prev_d});
            if (stall_b) check("burst_hold", {rd_data_burst_valid, rd_data_burst}, {1'b1, prev_b});
            if (rd_data_valid && rd_data_ready) begin
               got_q.push_back(rd_data);
               got_last_q.push_back(rd_data_last);
            end
            if (rd_data_burst_valid && rd_data_burst_ready) blen_q.push_back(int'(rd_data_burst));
            stall_w = rd_data_valid && !rd_data_ready;
            stall_b = rd_data_burst_valid && !rd_data_burst_ready;
            prev_d = rd_data; prev_l = rd_data_last; prev_b = rd_data_burst;
         end
      end
   end

   task automatic pulse_start(input bit record);
      @(negedge clk); #1;
      cfg_start = 1'b1;
      if (record) arm_edge = k;
      @(negedge clk); #1;
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk); #3;
         n++;
      end
      check(tag, done, 1'b1);
   endtask

   // Ticks fall on edges arm+(j+1)*(div+1); first matching tick is sample 0.
   task automatic build_model(input int div, input logic [31:0] mask, input logic [31:0] value,
                              input int count);
      int j = 0;
      int first = -1;
      int t;
      exp_q.delete();
      while (first < 0 && (arm_edge + (j + 1) * (div + 1)) < k) begin
         t = arm_edge + (j + 1) * (div + 1);
         if (((hist[t % 65536] ^ value) & mask) == 32'd0) first = j;
         j++;
      end
      if (first >= 0)
         for (int i = 0; i < count && i < DEPTH; i++)
            exp_q.push_back(hist[(arm_edge + (first + 1 + i) * (div + 1)) % 65536]);
   endtask

   task automatic compare_results(input logic exp_ovf);
      int n = exp_q.size();
      int nfull = n / BL;
      int rem = n % BL;
      int nb = nfull + ((rem != 0) ? 1 : 0);
      int bsz;
      check("word_count", got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         bsz = ((i / BL) < nfull) ? BL : rem;
         check($sformatf("word[%0d]", i), got_q[i], exp_q[i]);
         check($sformatf("last[%0d]", i), got_last_q[i], ((i % BL) == (bsz - 1)) ? 1'b1 : 1'b0);
      end
      check("burst_count", blen_q.size(), nb);
      for (int b = 0; b < nb && b < blen_q.size(); b++)
         check($sformatf("burst_len[%0d]", b), blen_q[b], (b < nfull) ? (BL - 1) : (rem - 1));
      check("final_status", {busy, done, triggered, overflow}, {1'b0, 1'b1, 1'b1, exp_ovf});
   endtask

   task automatic start_run(input int div, input logic [31:0] mask, input logic [31:0] value,
                            input int count, input int pm, input int rm, input int bm);
      cfg_sample_div = 16'(div); cfg_trig_mask = mask; cfg_trig_value = value;
      cfg_sample_count = 32'(count);
      pmode = pm; rmode = rm; bmode = bm;
      got_q.delete(); got_last_q.delete(); blen_q.delete();
      k0 = k + 1;
      pulse_start(1'b1);
   endtask

   task automatic run_capture(input int div, input logic [31:0] mask, input logic [31:0] value,
                              input int count, input int pm, input int rm, input int bm,
                              input int budget);
      start_run(div, mask, value, count, pm, rm, bm);
      wait_done(budget, "done_wait");
      build_model(div, mask, value, count);
      compare_results(1'b0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #3;
      check("reset_outputs", {busy, triggered, overflow, done, rd_data_burst_valid, rd_data_burst,
                              rd_data_valid, rd_data, rd_data_last}, 64'd0);
      @(negedge clk); #1 rstn = 1'b1;

      // Two full bursts of a counting probe.
      run_capture(0, 32'd0, 32'd0, 128, 0, 0, 1, 2000);
      check("consecutive", (got_q.size() > 127) ? (got_q[127] - got_q[0]) : 32'hFFFF_FFFF, 64'd127);

      // Masked trigger on low byte 0x5A.
      run_capture(0, 32'h0000_00FF, 32'h0000_005A, 10, 0, 0, 1, 2000);
      check("trigger_word", (got_q.size() > 0) ? got_q[0] : 32'hFFFF_FFFF, 64'h5A);
      check("partial_len", (blen_q.size() > 0) ? blen_q[0] : -1, 64'd9);

      // Divider of 4.
      run_capture(3, 32'd0, 32'd0, 4, 0, 0, 1, 500);
      check("div_step", (got_q.size() > 1) ? (got_q[1] - got_q[0]) : 32'hFFFF_FFFF, 64'd4);

      // Single-sample capture and zero-length arm.
      run_capture(1, 32'd0, 32'd0, 1, 1, 0, 1, 200);
      cfg_sample_count = 32'd0;
      got_q.delete();
      pulse_start(1'b1);
      #2;
      check("zero_count", {busy, done, triggered, overflow}, 4'b0100);

      // FIFO overflow with the burst channel stalled, then a start while busy.
      start_run(0, 32'd0, 32'd0, 1000, 1, 0, 0);
      repeat (1100) @(negedge clk);
      #3;
      check("overflow_stalled", {busy, done, overflow, triggered, rd_data_burst_valid}, 5'b10111);
      pulse_start(1'b0);
      bmode = 1;
      wait_done(3000, "done_wait_ovf");
      build_model(0, 32'd0, 32'd0, 1000);
      compare_results(1'b1);

      // Random probes, triggers and backpressure.
      for (int it = 0; it < 6; it++)
         run_capture($urandom_range(0, 3), 32'h3 << $urandom_range(0, 30), $urandom,
                     $urandom_range(1, 300), 1, 1, 2, 6000);

      // Soft clear in the middle of a burst, then a clean capture.
      start_run(0, 32'd0, 32'd0, 200, 0, 1, 1);
      n = 0;
      while (rd_data_valid !== 1'b1 && n < 500) begin
         @(negedge clk); #3;
         n++;
      end
      check("burst_started", rd_data_valid, 1'b1);
      repeat (5) @(negedge clk);
      #1 capture_rstn = 1'b0;
      @(negedge clk); #3;
      check("soft_reset_outputs", {busy, triggered, overflow, done, rd_data_burst_valid, rd_data_burst,
                                   rd_data_valid, rd_data, rd_data_last}, 64'd0);
      capture_rstn = 1'b1;
      run_capture(0, 32'd0, 32'd0, 70, 0, 1, 2, 3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
